// File: rtl/udma_evt_arbiter.sv
// ---------------------------------------------------------------------------
// udma_evt_arbiter
//
// Purpose: merges single-cycle event pulses from N_SRC uDMA peripherals onto
// one valid/data/ready event channel. Each source owns a saturating pending
// counter so simultaneous or back-pressured pulses are not lost. Pending
// sources are served round-robin through a one-entry registered output stage.
//
// Ports:
//   clk_i          clock
//   rstn_i         asynchronous active-low reset
//   evt_req_i      per-source event pulse, one event per cycle held high
//   ovf_clr_i      per-source clear of the sticky overflow flag
//   event_valid_o  event present on event_data_o
//   event_data_o   event code, EVT_BASE + source index
//   event_ready_i  consumer accepts the event
//   pending_o      bit i high while counter i is nonzero
//   overflow_o     sticky; bit i set when a pulse hits a saturated counter i
// ---------------------------------------------------------------------------
module udma_evt_arbiter #(
  parameter int N_SRC     = 8,
  parameter int CNT_WIDTH = 3,
  parameter int EVT_BASE  = 0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N_SRC-1:0] evt_req_i,
  input  logic [N_SRC-1:0] ovf_clr_i,
  output logic             event_valid_o,
  output logic [7:0]       event_data_o,
  input  logic             event_ready_i,
  output logic [N_SRC-1:0] pending_o,
  output logic [N_SRC-1:0] overflow_o
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [IDX_W-1:0] r_last_q, r_last_d;

  logic [N_SRC-1:0] pend;
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic             stage_free;
  logic             load;

  // Round-robin search starting just after the last granted source.
  // idx stays below 2*N_SRC, so a single subtraction handles the wrap.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(r_last_q) + 1 + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!grant_found && pend[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  // The output stage can take a new event when empty or when the held one
  // is being consumed this cycle, which gives one event per cycle.
  assign stage_free = (state_q == ST_EMPTY) || event_ready_i;
  assign load       = stage_free && grant_found;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    r_last_d = r_last_q;
    if (stage_free) begin
      if (grant_found) begin
        state_d  = ST_FULL;
        data_d   = 8'(EVT_BASE + int'(grant_idx));
        r_last_d = grant_idx;
      end else begin
        state_d  = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      r_last_q <= IDX_W'(N_SRC - 1);
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      r_last_q <= r_last_d;
    end
  end

  assign event_valid_o = (state_q == ST_FULL);
  assign event_data_o  = data_q;

  // Per-source pending counter and sticky overflow flag.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 inc, dec;

    assign inc = evt_req_i[gi];
    assign dec = load && (grant_idx == IDX_W'(gi));

    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (ovf_clr_i[gi]) ovf_d = 1'b0;
      if (inc && !dec) begin
        // A pulse on a full counter is dropped; the flag set overrides a clear.
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign pend[gi]       = (cnt_q != '0);
    assign overflow_o[gi] = ovf_q;
  end

  assign pending_o = pend;

endmodule

// File: tb/tb_udma_evt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_udma_evt_arbiter
//
// Directed scenarios for udma_evt_arbiter with N_SRC=8, CNT_WIDTH=3,
// EVT_BASE=0. Inputs change 1 time unit after the rising edge; outputs are
// observed at that same point, i.e. reflecting the edge just taken.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_udma_evt_arbiter;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [7:0] evt_req_i;
  logic [7:0] ovf_clr_i;
  logic       event_valid_o;
  logic [7:0] event_data_o;
  logic       event_ready_i;
  logic [7:0] pending_o;
  logic [7:0] overflow_o;

  int checks = 0;
  int passes = 0;

  udma_evt_arbiter #(
    .N_SRC(8),
    .CNT_WIDTH(3),
    .EVT_BASE(0)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .evt_req_i(evt_req_i),
    .ovf_clr_i(ovf_clr_i),
    .event_valid_o(event_valid_o),
    .event_data_o(event_data_o),
    .event_ready_i(event_ready_i),
    .pending_o(pending_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i        = 1'b0;
    evt_req_i     = '0;
    ovf_clr_i     = '0;
    event_ready_i = 1'b0;
    tick();
    tick();
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (event_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", event_valid_o);
    else passes++;
    checks++;
    if (event_data_o !== 8'h00) $display("FAIL reset_data got=%0d exp=0", event_data_o);
    else passes++;
    checks++;
    if (pending_o !== 8'h00) $display("FAIL reset_pending got=%h exp=00", pending_o);
    else passes++;
    checks++;
    if (overflow_o !== 8'h00) $display("FAIL reset_overflow got=%h exp=00", overflow_o);
    else passes++;
  endtask

  task automatic test_single_pulse();
    do_reset();
    event_ready_i = 1'b1;
    evt_req_i = 8'h08;
    tick();
    evt_req_i = 8'h00;
    checks++;
    if ({event_valid_o, pending_o} !== {1'b0, 8'h08})
      $display("FAIL single_t1 got valid=%b pend=%h exp valid=0 pend=08", event_valid_o, pending_o);
    else passes++;
    tick();
    checks++;
    if ({event_valid_o, event_data_o, pending_o} !== {1'b1, 8'd3, 8'h00})
      $display("FAIL single_t2 got valid=%b data=%0d pend=%h exp valid=1 data=3 pend=00",
               event_valid_o, event_data_o, pending_o);
    else passes++;
    $display("single: event code %0d", event_data_o);
    tick();
    checks++;
    if (event_valid_o !== 1'b0) $display("FAIL single_t3 got valid=%b exp=0", event_valid_o);
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_rr [3];
    exp_rr[0] = 8'd1;
    exp_rr[1] = 8'd2;
    exp_rr[2] = 8'd5;
    do_reset();
    event_ready_i = 1'b1;
    evt_req_i = 8'h26;
    tick();
    evt_req_i = 8'h00;
    checks++;
    if (pending_o !== 8'h26) $display("FAIL rr_pending got=%h exp=26", pending_o);
    else passes++;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        checks++;
        if ({event_valid_o, event_data_o} !== {1'b1, exp_rr[i]})
          $display("FAIL rr_order pass=%0d slot=%0d got valid=%b data=%0d exp valid=1 data=%0d",
                   pass, i, event_valid_o, event_data_o, exp_rr[i]);
        else passes++;
        $display("rr: pass %0d event code %0d", pass, event_data_o);
      end
      // Re-pulse the same three sources while code 5 is being accepted.
      if (pass == 0) begin
        evt_req_i = 8'h26;
        tick();
        evt_req_i = 8'h00;
        checks++;
        if ({event_valid_o, pending_o} !== {1'b0, 8'h26})
          $display("FAIL rr_gap got valid=%b pend=%h exp valid=0 pend=26", event_valid_o, pending_o);
        else passes++;
      end
    end
    tick();
    checks++;
    if (event_valid_o !== 1'b0) $display("FAIL rr_end got valid=%b exp=0", event_valid_o);
    else passes++;
  endtask

  task automatic test_back_pressure();
    do_reset();
    event_ready_i = 1'b0;
    evt_req_i = 8'h01;
    for (int i = 0; i < 3; i++) tick();
    evt_req_i = 8'h00;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({event_valid_o, event_data_o, pending_o} !== {1'b1, 8'd0, 8'h01})
        $display("FAIL bp_hold cyc=%0d got valid=%b data=%0d pend=%h exp valid=1 data=0 pend=01",
                 i, event_valid_o, event_data_o, pending_o);
      else passes++;
      tick();
    end
    event_ready_i = 1'b1;
    // Held event plus two remaining counts: three accepts, then empty.
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({event_valid_o, event_data_o} !== {1'b1, 8'd0})
        $display("FAIL bp_drain acc=%0d got valid=%b data=%0d exp valid=1 data=0",
                 i, event_valid_o, event_data_o);
      else passes++;
      $display("bp: accept %0d code %0d", i, event_data_o);
      tick();
    end
    checks++;
    if ({event_valid_o, pending_o} !== {1'b0, 8'h00})
      $display("FAIL bp_empty got valid=%b pend=%h exp valid=0 pend=00", event_valid_o, pending_o);
    else passes++;
  endtask

  task automatic test_saturation();
    int delivered;
    do_reset();
    event_ready_i = 1'b0;
    evt_req_i = 8'h10;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if ({event_valid_o, event_data_o, pending_o, overflow_o} !== {1'b1, 8'd4, 8'h10, 8'h10})
      $display("FAIL sat_state got valid=%b data=%0d pend=%h ovf=%h exp valid=1 data=4 pend=10 ovf=10",
               event_valid_o, event_data_o, pending_o, overflow_o);
    else passes++;
    ovf_clr_i = 8'h10;
    tick();
    checks++;
    if (overflow_o !== 8'h10) $display("FAIL sat_set_wins got ovf=%h exp=10", overflow_o);
    else passes++;
    evt_req_i = 8'h00;
    tick();
    ovf_clr_i = 8'h00;
    checks++;
    if (overflow_o !== 8'h00) $display("FAIL sat_clear got ovf=%h exp=00", overflow_o);
    else passes++;
    event_ready_i = 1'b1;
    delivered = 0;
    for (int i = 0; i < 20; i++) begin
      if (event_valid_o) begin
        delivered++;
        checks++;
        if (event_data_o !== 8'd4) $display("FAIL sat_code n=%0d got=%0d exp=4", delivered, event_data_o);
        else passes++;
      end
      tick();
    end
    $display("sat: delivered %0d events", delivered);
    checks++;
    if (delivered !== 8) $display("FAIL sat_count got=%0d exp=8", delivered);
    else passes++;
    checks++;
    if ({pending_o, overflow_o} !== {8'h00, 8'h00})
      $display("FAIL sat_final got pend=%h ovf=%h exp pend=00 ovf=00", pending_o, overflow_o);
    else passes++;
  endtask

  task automatic test_inc_dec();
    do_reset();
    event_ready_i = 1'b1;
    evt_req_i = 8'h40;
    tick();
    // Counter is 1 here; next edge grants source 6 while it pulses again.
    tick();
    evt_req_i = 8'h00;
    checks++;
    if ({event_valid_o, event_data_o, pending_o} !== {1'b1, 8'd6, 8'h40})
      $display("FAIL incdec_first got valid=%b data=%0d pend=%h exp valid=1 data=6 pend=40",
               event_valid_o, event_data_o, pending_o);
    else passes++;
    tick();
    checks++;
    if ({event_valid_o, event_data_o, pending_o} !== {1'b1, 8'd6, 8'h00})
      $display("FAIL incdec_second got valid=%b data=%0d pend=%h exp valid=1 data=6 pend=00",
               event_valid_o, event_data_o, pending_o);
    else passes++;
    tick();
    checks++;
    if (event_valid_o !== 1'b0) $display("FAIL incdec_end got valid=%b exp=0", event_valid_o);
    else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    event_ready_i = 1'b0;
    evt_req_i = 8'h04;
    for (int i = 0; i < 10; i++) tick();
    evt_req_i = 8'h20;
    tick();
    evt_req_i = 8'h00;
    checks++;
    if ({event_valid_o, pending_o, overflow_o} !== {1'b1, 8'h24, 8'h04})
      $display("FAIL areset_pre got valid=%b pend=%h ovf=%h exp valid=1 pend=24 ovf=04",
               event_valid_o, pending_o, overflow_o);
    else passes++;
    // Assert reset between edges and look before the next edge arrives.
    #1;
    rstn_i = 1'b0;
    #1;
    checks++;
    if ({event_valid_o, event_data_o, pending_o, overflow_o} !== {1'b0, 8'd0, 8'h00, 8'h00})
      $display("FAIL areset_clear got valid=%b data=%0d pend=%h ovf=%h exp all zero",
               event_valid_o, event_data_o, pending_o, overflow_o);
    else passes++;
    tick();
    rstn_i = 1'b1;
    event_ready_i = 1'b1;
    evt_req_i = 8'h49;
    tick();
    evt_req_i = 8'h00;
    tick();
    checks++;
    if ({event_valid_o, event_data_o} !== {1'b1, 8'd0})
      $display("FAIL areset_first_grant got valid=%b data=%0d exp valid=1 data=0",
               event_valid_o, event_data_o);
    else passes++;
    tick();
    checks++;
    if ({event_valid_o, event_data_o} !== {1'b1, 8'd3})
      $display("FAIL areset_second_grant got valid=%b data=%0d exp valid=1 data=3",
               event_valid_o, event_data_o);
    else passes++;
  endtask

  initial begin
    rstn_i        = 1'b0;
    evt_req_i     = '0;
    ovf_clr_i     = '0;
    event_ready_i = 1'b0;
    test_reset();
    test_single_pulse();
    test_round_robin();
    test_back_pressure();
    test_saturation();
    test_inc_dec();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/udma_evt_arbiter.md
Name: udma_evt_arbiter

Overview:
- Merges event pulses from N_SRC uDMA peripherals onto the single event channel of the uDMA configuration/event block.
- That channel is a valid/data/ready handshake; the event code is 8 bits wide.
- Keeps a saturating pending count per source so back-pressured or simultaneous pulses are not lost.
- Picks among pending sources round-robin and presents one registered event per accepted handshake.

Parameters:
N_SRC, 8, number of event sources; legal range 1..(256-EVT_BASE)
CNT_WIDTH, 3, width of each per-source pending counter; saturates at 2^CNT_WIDTH-1
EVT_BASE, 0, 8-bit code offset; source i emits code EVT_BASE+i

Ports:
clk_i  input  1  clock
rstn_i  input  1  asynchronous active-low reset
evt_req_i  input  N_SRC  per-source event pulse; each cycle high counts as one event
ovf_clr_i  input  N_SRC  per-source clear of the sticky overflow flag
event_valid_o  output  1  event present on event_data_o
event_data_o  output  8  event code, EVT_BASE+source index
event_ready_i  input  1  consumer accepts the event
pending_o  output  N_SRC  bit i high when counter i != 0
overflow_o  output  N_SRC  sticky; bit i set when a pulse arrives on a saturated counter i

Behaviour:
- Clock and reset: single clock clk_i; reset rstn_i is asynchronous, active-low.
- Reset values:
  - all counters = 0; overflow_o = 0; pending_o = 0
  - event_valid_o = 0; event_data_o = 0
  - round-robin pointer r_last = N_SRC-1, so source 0 has first priority after reset.
- Output stage FSM, state held in event_valid_o:
  - ST_EMPTY (valid=0): if any counter != 0, load the granted code and go to ST_FULL; otherwise stay.
  - ST_FULL (valid=1): event_data_o is held stable while event_ready_i=0.
  - On valid&ready in ST_FULL: if any counter (after this cycle's grant rules) != 0, load the next grant in the same edge and stay ST_FULL (1 event/cycle throughput). Otherwise go to ST_EMPTY.
  - Stage is free this cycle = ST_EMPTY or (valid&ready).
- Grant (combinational):
  - Candidates are sources with counter != 0, searched from (r_last+1) mod N_SRC upward with wrap.
  - First hit is the grant. On load, r_last <= granted index and the code EVT_BASE+index is registered.
  - No load → r_last unchanged.
- Counter update per source i, each edge:
  - inc = evt_req_i[i]; dec = (stage free and grant == i).
  - inc&dec → unchanged; inc only → +1; dec only → -1.
  - inc only at max → value stays at max and overflow_o[i] <= 1; the event is dropped.
  - A counter at 0 is never granted, so underflow cannot occur.
- Overflow flags:
  - overflow_o[i] cleared by ovf_clr_i[i].
  - Set in the same cycle as clear → set wins.
- Latency:
  - Pulse at cycle t makes the counter nonzero after edge t.
  - If the stage is free in cycle t+1, event_valid_o=1 after edge t+1, i.e. 2 cycles from request to valid.
  - No combinational path from evt_req_i or event_ready_i to event_valid_o/event_data_o.
- pending_o reflects counters after the edge (registered counters compared to 0).
- Reset mid-operation clears everything immediately. Outstanding counts and the held event are discarded.

Test Plan:
- Single pulse, ready=1: evt_req_i[3] high one cycle at t → event_valid_o=1 with event_data_o=3 during cycle t+2 only; pending_o[3] high only during t+1.
- Round-robin fairness: sources 1, 2, 5 pulsed together, ready=1 → codes 1, 2, 5 on three consecutive cycles. Pulsing all three again right after → order continues 1, 2, 5 (pointer at 5 wraps to 1).
- Back-pressure hold: ready=0, source 0 pulsed 3 times → valid=1, data=0 stable, counter[0] shows 2 remaining. Raising ready for 3 cycles → 0,0,0 accepted, then valid drops.
- Saturation: CNT_WIDTH=3, ready=0, source 4 pulsed 10 times → counter stops at 7 and overflow_o[4]=1. Pulse with ovf_clr_i[4] in the same cycle → flag stays 1; clear alone → flag 0. With ready=1, exactly 8 events delivered (1 held in the output stage + 7 pending).
- Simultaneous inc/dec: source 6 counter=1 and granted on the same cycle it pulses → counter remains 1, and a second event follows on the next cycle.
- Async reset: assert rstn_i mid-stream with valid=1 → event_valid_o, pending_o and overflow_o go to 0 without a clock edge. The first grant after release goes to the lowest-indexed pending source (source 0 if pending).
